// File: rtl/div_pkg.sv
// Shared encodings for the iterative RV32M divider.
// Op codes, FSM states, iteration count and a negate helper.
package div_pkg;

  localparam int DIV_W     = 32;
  localparam int DIV_ITERS = 32;

  localparam logic [1:0] OP_DIV  = 2'b00;
  localparam logic [1:0] OP_DIVU = 2'b01;
  localparam logic [1:0] OP_REM  = 2'b10;
  localparam logic [1:0] OP_REMU = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    FIX  = 2'b10,
    DONE = 2'b11
  } div_state_e;

  function automatic logic [DIV_W-1:0] neg(
    input logic [DIV_W-1:0] x
  );
    return '0 - x;
  endfunction

endpackage

// File: rtl/div_unit_cla.sv
// 32-bit carry-lookahead adder: 4-bit lookahead groups,
// with the group carries chained by group generate/propagate.
module CL_adder_32 (
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        c_in,
  output logic [31:0] S,
  output logic        c_out
);

  always_comb begin
    logic [31:0] g;
    logic [31:0] p;
    logic [32:0] c;
    logic        gg;
    logic        gp;
    g    = A & B;
    p    = A ^ B;
    c    = '0;
    c[0] = c_in;
    for (int k = 0; k < 8; k++) begin
      for (int j = 0; j < 3; j++) begin
        c[4*k+j+1] = g[4*k+j] | (p[4*k+j] & c[4*k+j]);
      end
      gg = g[4*k+3]
         | (p[4*k+3] & g[4*k+2])
         | (p[4*k+3] & p[4*k+2] & g[4*k+1])
         | (p[4*k+3] & p[4*k+2] & p[4*k+1] & g[4*k]);
      gp = &p[4*k +: 4];
      c[4*k+4] = gg | (gp & c[4*k]);
    end
    S     = p ^ c[31:0];
    c_out = c[32];
  end

endmodule

// File: rtl/div_unit.sv
// Restoring divider for DIV/DIVU/REM/REMU, one quotient bit
// per cycle, with valid/ready on both request and result sides.
module div_unit
  import div_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result
);

  div_state_e  state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [31:0] rem_q, rem_d;
  logic [31:0] dvd_q, dvd_d;
  logic [31:0] dsr_q, dsr_d;
  logic [31:0] res_q, res_d;
  logic        sel_rem_q, sel_rem_d;
  logic        neg_q, neg_d;

  logic        accept;
  logic        is_signed;
  logic        is_rem;
  logic        b_zero;
  logic        ovf;
  logic [31:0] a_abs;
  logic [31:0] b_abs;
  logic [31:0] t_lo;
  logic [31:0] sum;
  logic        c_out;
  logic        sub_ok;
  logic [31:0] fix_val;

  assign accept    = in_valid && in_ready;
  assign is_signed = (op == OP_DIV) || (op == OP_REM);
  assign is_rem    = (op == OP_REM) || (op == OP_REMU);
  assign b_zero    = (b == '0);
  assign ovf       = is_signed
                  && (a == 32'h8000_0000)
                  && (b == 32'hFFFF_FFFF);
  assign a_abs     = (is_signed && a[31]) ? neg(a) : a;
  assign b_abs     = (is_signed && b[31]) ? neg(b) : b;

  // Trial subtract of the shifted partial remainder;
  // bit 32 of t is rem_q[31], which forces success.
  assign t_lo   = {rem_q[30:0], dvd_q[31]};
  assign sub_ok = rem_q[31] | c_out;

  CL_adder_32 u_cla (
    .A    (t_lo),
    .B    (~dsr_q),
    .c_in (1'b1),
    .S    (sum),
    .c_out(c_out)
  );

  assign fix_val = sel_rem_q ? rem_q : dvd_q;

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (accept) state_d = (b_zero || ovf) ? DONE : RUN;
      RUN:  if (cnt_q == 5'(DIV_ITERS - 1)) state_d = FIX;
      FIX:  state_d = DONE;
      DONE: if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == IDLE) && !rst;
    out_valid = (state_q == DONE) && !rst;
    result    = res_q;
  end

  always_comb begin
    cnt_d     = cnt_q;
    rem_d     = rem_q;
    dvd_d     = dvd_q;
    dsr_d     = dsr_q;
    res_d     = res_q;
    sel_rem_d = sel_rem_q;
    neg_d     = neg_q;
    unique case (state_q)
      IDLE: if (accept) begin
        cnt_d     = '0;
        rem_d     = '0;
        dvd_d     = a_abs;
        dsr_d     = b_abs;
        sel_rem_d = is_rem;
        neg_d     = is_rem ? (is_signed & a[31])
                           : (is_signed & (a[31] ^ b[31]));
        if (b_zero)   res_d = is_rem ? a : 32'hFFFF_FFFF;
        else if (ovf) res_d = is_rem ? 32'h0 : 32'h8000_0000;
      end
      RUN: begin
        rem_d = sub_ok ? sum : t_lo;
        dvd_d = {dvd_q[30:0], sub_ok};
        cnt_d = cnt_q + 5'd1;
      end
      FIX:  res_d = neg_q ? neg(fix_val) : fix_val;
      DONE: ;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q     <= '0;
      rem_q     <= '0;
      dvd_q     <= '0;
      dsr_q     <= '0;
      res_q     <= '0;
      sel_rem_q <= 1'b0;
      neg_q     <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      rem_q     <= rem_d;
      dvd_q     <= dvd_d;
      dsr_q     <= dsr_d;
      res_q     <= res_d;
      sel_rem_q <= sel_rem_d;
      neg_q     <= neg_d;
    end
  end

endmodule

// File: tb/tb_div_unit.sv
// Directed bench for div_unit: normal, signed, special-case,
// backpressure and mid-operation reset scenarios.
module tb_div_unit;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;

  int total;
  int bad;

  div_unit #(.XLEN(32)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .op       (op),
    .a        (a),
    .b        (b),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .result   (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Issue one request and wait for its result; lat counts
  // cycles from the accept edge to the first out_valid cycle.
  task automatic run_op(
    input  logic [1:0]  o,
    input  logic [31:0] av,
    input  logic [31:0] bv,
    output logic [31:0] res,
    output int          lat
  );
    in_valid = 1'b1;
    op       = o;
    a        = av;
    b        = bv;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    a        = 32'hDEAD_BEEF;
    b        = 32'h0BAD_F00D;
    lat      = 1;
    while (!out_valid && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
    end
    res = result;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    op        = 2'b00;
    a         = '0;
    b         = '0;
    repeat (2) @(posedge clk);
    #1;
    total++;
    if (in_ready !== 1'b0) begin
      bad++;
      $display("FAIL reset_in_ready got=%b exp=0", in_ready);
    end
    total++;
    if (out_valid !== 1'b0 || result !== 32'h0) begin
      bad++;
      $display("FAIL reset_out got=%b/%h exp=0/0",
               out_valid, result);
    end
    rst = 1'b0;
    #1;
    total++;
    if (in_ready !== 1'b1) begin
      bad++;
      $display("FAIL idle_in_ready got=%b exp=1", in_ready);
    end
  endtask

  task automatic test_unsigned();
    logic [31:0] r;
    int          l;
    run_op(2'b01, 32'd100, 32'd7, r, l);
    total++;
    if (r !== 32'h0000_000E) begin
      bad++;
      $display("FAIL divu_100_7 got=%h exp=0000000e", r);
    end
    total++;
    if (l !== 34) begin
      bad++;
      $display("FAIL divu_latency got=%0d exp=34", l);
    end
    run_op(2'b11, 32'd100, 32'd7, r, l);
    total++;
    if (r !== 32'h0000_0002) begin
      bad++;
      $display("FAIL remu_100_7 got=%h exp=00000002", r);
    end
    run_op(2'b01, 32'hFFFF_FFFF, 32'd1, r, l);
    total++;
    if (r !== 32'hFFFF_FFFF) begin
      bad++;
      $display("FAIL divu_max_1 got=%h exp=ffffffff", r);
    end
    run_op(2'b11, 32'hFFFF_FFFF, 32'h8000_0000, r, l);
    total++;
    if (r !== 32'h7FFF_FFFF) begin
      bad++;
      $display("FAIL remu_max_msb got=%h exp=7fffffff", r);
    end
  endtask

  task automatic test_signed();
    logic [31:0] r;
    int          l;
    run_op(2'b00, 32'hFFFF_FFF9, 32'd2, r, l);
    total++;
    if (r !== 32'hFFFF_FFFD) begin
      bad++;
      $display("FAIL div_m7_2 got=%h exp=fffffffd", r);
    end
    run_op(2'b10, 32'hFFFF_FFF9, 32'd2, r, l);
    total++;
    if (r !== 32'hFFFF_FFFF) begin
      bad++;
      $display("FAIL rem_m7_2 got=%h exp=ffffffff", r);
    end
    run_op(2'b00, 32'd7, 32'hFFFF_FFFE, r, l);
    total++;
    if (r !== 32'hFFFF_FFFD) begin
      bad++;
      $display("FAIL div_7_m2 got=%h exp=fffffffd", r);
    end
    run_op(2'b10, 32'd7, 32'hFFFF_FFFE, r, l);
    total++;
    if (r !== 32'h0000_0001) begin
      bad++;
      $display("FAIL rem_7_m2 got=%h exp=00000001", r);
    end
    run_op(2'b00, 32'hFFFF_FFF8, 32'hFFFF_FFFE, r, l);
    total++;
    if (r !== 32'h0000_0004) begin
      bad++;
      $display("FAIL div_m8_m2 got=%h exp=00000004", r);
    end
  endtask

  task automatic test_div_zero();
    logic [31:0] r;
    int          l;
    run_op(2'b00, 32'h1234_5678, 32'h0, r, l);
    total++;
    if (r !== 32'hFFFF_FFFF) begin
      bad++;
      $display("FAIL div_by_zero got=%h exp=ffffffff", r);
    end
    total++;
    if (l !== 1) begin
      bad++;
      $display("FAIL div_zero_latency got=%0d exp=1", l);
    end
    run_op(2'b11, 32'h1234_5678, 32'h0, r, l);
    total++;
    if (r !== 32'h1234_5678) begin
      bad++;
      $display("FAIL remu_by_zero got=%h exp=12345678", r);
    end
    run_op(2'b10, 32'h8765_4321, 32'h0, r, l);
    total++;
    if (r !== 32'h8765_4321) begin
      bad++;
      $display("FAIL rem_by_zero got=%h exp=87654321", r);
    end
  endtask

  task automatic test_overflow();
    logic [31:0] r;
    int          l;
    run_op(2'b00, 32'h8000_0000, 32'hFFFF_FFFF, r, l);
    total++;
    if (r !== 32'h8000_0000) begin
      bad++;
      $display("FAIL div_ovf got=%h exp=80000000", r);
    end
    total++;
    if (l !== 1) begin
      bad++;
      $display("FAIL div_ovf_latency got=%0d exp=1", l);
    end
    run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, r, l);
    total++;
    if (r !== 32'h0000_0000 || l !== 1) begin
      bad++;
      $display("FAIL rem_ovf got=%h/%0d exp=00000000/1", r, l);
    end
  endtask

  task automatic test_backpressure();
    int n;
    int errs;
    out_ready = 1'b0;
    in_valid  = 1'b1;
    op        = 2'b01;
    a         = 32'd100;
    b         = 32'd7;
    @(posedge clk);
    #1;
    a = 32'd50;
    b = 32'd5;
    n = 0;
    while (!out_valid && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    errs = 0;
    for (int i = 0; i < 5; i++) begin
      if (out_valid !== 1'b1 || result !== 32'h0000_000E
          || in_ready !== 1'b0) errs++;
      @(posedge clk);
      #1;
    end
    total++;
    if (errs !== 0) begin
      bad++;
      $display("FAIL bp_hold got=%0d bad cycles exp=0 (res=%h)",
               errs, result);
    end
    out_ready = 1'b1;
    total++;
    if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
      bad++;
      $display("FAIL bp_handshake got=%b/%b exp=1/0",
               out_valid, in_ready);
    end
    @(posedge clk);
    #1;
    total++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      bad++;
      $display("FAIL bp_release got=%b/%b exp=1/0",
               in_ready, out_valid);
    end
    in_valid = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset_mid();
    logic [31:0] r;
    int          l;
    int          errs;
    in_valid = 1'b1;
    op       = 2'b01;
    a        = 32'hFFFF_FFFF;
    b        = 32'd3;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    total++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0
        || result !== 32'h0) begin
      bad++;
      $display("FAIL mid_reset got=%b/%b/%h exp=1/0/0",
               in_ready, out_valid, result);
    end
    errs = 0;
    for (int i = 0; i < 40; i++) begin
      if (out_valid !== 1'b0) errs++;
      @(posedge clk);
      #1;
    end
    total++;
    if (errs !== 0) begin
      bad++;
      $display("FAIL aborted_output got=%0d exp=0", errs);
    end
    run_op(2'b01, 32'd9, 32'd3, r, l);
    total++;
    if (r !== 32'h0000_0003) begin
      bad++;
      $display("FAIL post_reset_divu got=%h exp=00000003", r);
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_unsigned();
    test_signed();
    test_div_zero();
    test_overflow();
    test_backpressure();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
